inverse_funct: RTL and testbench

- Sequential inverse of the square/cubic/factorial function unit.
- Given an 8-bit value and an opcode, it finds the largest n in 0..15 whose function result f(n) is less than or equal to the value, and flags whether the match is exact.
- Evaluates one candidate per clock using incremental arithmetic, with no multiplier, behind a start/done handshake.
- Sits beside the forward function unit in the arithmetic exercise datapath.

---
 rtl/inverse_funct_pkg.sv | 37 +++
 rtl/inv_step_gen.sv | 60 ++++++
 rtl/inverse_funct.sv | 113 +++++++++++
 tb/tb_inverse_funct.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/inverse_funct_pkg.sv
// Shared widths, opcodes, FSM encoding and saturation helpers for the inverse
// square/cubic/factorial search unit.
package inverse_funct_pkg;

    localparam int unsigned N_W    = 4;
    localparam int unsigned V_W    = 8;
    localparam int unsigned ACC_W  = 12;
    localparam int unsigned MATH_W = 16;

    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [N_W-1:0]   K_MAX   = {N_W{1'b1}};

    localparam logic [2:0] OP_SQUARE    = 3'd0;
    localparam logic [2:0] OP_CUBIC     = 3'd1;
    localparam logic [2:0] OP_FACTORIAL = 3'd2;

    typedef enum logic [1:0] {
        StIdle,
        StSearch,
        StDone
    } state_e;

    function automatic logic op_valid(input logic [2:0] op);
        return (op == OP_SQUARE) || (op == OP_CUBIC) || (op == OP_FACTORIAL);
    endfunction

    // f(0) for each valid opcode.
    function automatic logic [ACC_W-1:0] f_zero(input logic [2:0] op);
        return (op == OP_FACTORIAL) ? ACC_W'(1) : '0;
    endfunction

    // Clamp a wide intermediate into the accumulator; ACC_MAX exceeds any V_W value.
    function automatic logic [ACC_W-1:0] sat_acc(input logic [MATH_W-1:0] x);
        return (x > MATH_W'(ACC_MAX)) ? ACC_MAX : x[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/inv_step_gen.sv
// Combinational step generator: f(k+1) from f(k) (and k^2 for cubic) using
// only adds and shifts, saturated to the accumulator width.
module inv_step_gen
    import inverse_funct_pkg::*;
(
    input  logic [2:0]       opcode_i,
    input  logic [N_W-1:0]   k_i,
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] sq_i,
    output logic [ACC_W-1:0] nxt_o,
    output logic [ACC_W-1:0] sq_nxt_o
);

    logic [MATH_W-1:0] k_w;
    logic [MATH_W-1:0] acc_w;
    logic [MATH_W-1:0] sq_w;
    logic [MATH_W-1:0] odd_w;
    logic [MATH_W-1:0] square_w;
    logic [MATH_W-1:0] cube_w;
    logic [MATH_W-1:0] fact_w;
    logic [MATH_W-1:0] nxt_w;
    logic [N_W-1:0]    mult;

    assign k_w   = MATH_W'(k_i);
    assign acc_w = MATH_W'(acc_i);
    assign sq_w  = MATH_W'(sq_i);

    // (k+1)^2 - k^2 = 2k + 1
    assign odd_w    = (k_w << 1) + MATH_W'(1);
    assign square_w = acc_w + odd_w;

    // (k+1)^3 - k^3 = 3k^2 + 3k + 1
    assign cube_w = acc_w + (sq_w << 1) + sq_w + (k_w << 1) + k_w + MATH_W'(1);

    // k+1 only needs N_W bits while the search can still advance (k < K_MAX).
    assign mult = k_i + N_W'(1);

    always_comb begin
        fact_w = '0;
        for (int i = 0; i < int'(N_W); i++) begin
            if (mult[i]) begin
                fact_w = fact_w + (acc_w << i);
            end
        end
    end

    always_comb begin
        nxt_w = MATH_W'(ACC_MAX);
        case (opcode_i)
            OP_SQUARE:    nxt_w = square_w;
            OP_CUBIC:     nxt_w = cube_w;
            OP_FACTORIAL: nxt_w = fact_w;
            default:      nxt_w = MATH_W'(ACC_MAX);
        endcase
    end

    assign nxt_o    = sat_acc(nxt_w);
    assign sq_nxt_o = sat_acc(sq_w + odd_w);

endmodule

// File: rtl/inverse_funct.sv
// Sequential inverse of square/cubic/factorial: finds the largest n in 0..15
// with f(n) <= value, one candidate per clock, behind a start/done handshake.
module inverse_funct
    import inverse_funct_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    input  logic [2:0]     opcode_i,
    input  logic [V_W-1:0] value_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [N_W-1:0] n_out_o,
    output logic           exact_o,
    output logic           err_o
);

    state_e           state_q;
    logic [N_W-1:0]   k_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sq_q;
    logic [V_W-1:0]   value_q;
    logic [2:0]       opcode_q;
    logic [N_W-1:0]   n_out_q;
    logic             exact_q;
    logic             err_q;
    logic             done_q;
    logic             busy_q;

    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sq_d;
    logic             advance;

    inv_step_gen u_step_gen (
        .opcode_i (opcode_q),
        .k_i      (k_q),
        .acc_i    (acc_q),
        .sq_i     (sq_q),
        .nxt_o    (acc_d),
        .sq_nxt_o (sq_d)
    );

    // Saturated acc_d is always above any V_W value, so this never over-advances.
    assign advance = (acc_d <= ACC_W'(value_q)) && (k_q != K_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            acc_q    <= '0;
            sq_q     <= '0;
            value_q  <= '0;
            opcode_q <= '0;
            n_out_q  <= '0;
            exact_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        value_q  <= value_i;
                        opcode_q <= opcode_i;
                        n_out_q  <= '0;
                        exact_q  <= 1'b0;
                        k_q      <= '0;
                        sq_q     <= '0;
                        busy_q   <= 1'b1;
                        if (op_valid(opcode_i)) begin
                            acc_q   <= f_zero(opcode_i);
                            err_q   <= 1'b0;
                            state_q <= StSearch;
                        end else begin
                            acc_q   <= '0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StSearch: begin
                    if (advance) begin
                        k_q   <= k_q + N_W'(1);
                        acc_q <= acc_d;
                        sq_q  <= sq_d;
                    end else begin
                        n_out_q <= k_q;
                        exact_q <= (acc_q == ACC_W'(value_q));
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign n_out_o = n_out_q;
    assign exact_o = exact_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_inverse_funct.sv
// Scoreboard bench for inverse_funct: expected results come from a
// full-precision reference model and are checked when done pulses.
module tb_inverse_funct;
    import inverse_funct_pkg::*;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start_i = 1'b0;
    logic [2:0]     opcode_i = '0;
    logic [V_W-1:0] value_i = '0;
    logic           busy_o;
    logic           done_o;
    logic [N_W-1:0] n_out_o;
    logic           exact_o;
    logic           err_o;

    inverse_funct dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .opcode_i (opcode_i),
        .value_i  (value_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .n_out_o  (n_out_o),
        .exact_o  (exact_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int n;
        int exact;
        int err;
        int done_edge;
        int busy_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_run = 0;

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Reference: largest k in 0..15 with f(k) <= v, computed at full precision.
    function automatic void model(input logic [2:0] op, input int v,
                                  output int n, output int ex, output int er);
        longint f;
        n  = 0;
        ex = 0;
        er = 0;
        if (op > 3'd2) begin
            er = 1;
            return;
        end
        for (int k = 0; k < 16; k++) begin
            if (op == 3'd0) begin
                f = longint'(k * k);
            end else if (op == 3'd1) begin
                f = longint'(k * k * k);
            end else begin
                f = 1;
                for (int j = 2; j <= k; j++) f = f * j;
            end
            if (f <= longint'(v)) begin
                n  = k;
                ex = (f == longint'(v)) ? 1 : 0;
            end
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset || !busy_o) busy_run = 0;
            else busy_run = busy_run + 1;
            if (done_o) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_done", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_eq("n_out", int'(n_out_o), e.n);
                    check_eq("exact", int'(exact_o), e.exact);
                    check_eq("err", int'(err_o), e.err);
                    check_eq("latency", cyc, e.done_edge);
                    check_eq("busy_cycles", busy_run, e.busy_cyc);
                end
            end
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [7:0] v);
        exp_t e;
        int   n, ex, er, edge_e;
        @(negedge clk);
        start_i  = 1'b1;
        opcode_i = op;
        value_i  = v;
        @(posedge clk);
        #1;
        edge_e   = cyc;
        start_i  = 1'b0;
        opcode_i = 3'($urandom);
        value_i  = 8'($urandom);
        model(op, int'(v), n, ex, er);
        e.n         = n;
        e.exact     = ex;
        e.err       = er;
        e.done_edge = (er != 0) ? edge_e : edge_e + n + 1;
        e.busy_cyc  = (er != 0) ? 1 : n + 2;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            check_eq("timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [7:0] v);
        start_op(op, v);
        wait_done();
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_busy"}, int'(busy_o), 0);
        check_eq({tag, "_done"}, int'(done_o), 0);
        check_eq({tag, "_n_out"}, int'(n_out_o), 0);
        check_eq({tag, "_exact"}, int'(exact_o), 0);
        check_eq({tag, "_err"}, int'(err_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, want < 20000", cyc);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd0, 8'd50);
        run_op(3'd0, 8'd225);
        run_op(3'd1, 8'd27);
        run_op(3'd1, 8'd255);
        run_op(3'd1, 8'd0);
        run_op(3'd2, 8'd120);
        run_op(3'd2, 8'd1);
        run_op(3'd2, 8'd0);
        run_op(3'd2, 8'd255);
        run_op(3'd3, 8'd77);
        run_op(3'd7, 8'd200);

        // Starts during SEARCH must not disturb the captured operands.
        start_op(3'd0, 8'd200);
        repeat (2) @(negedge clk);
        start_i  = 1'b1;
        opcode_i = 3'd1;
        value_i  = 8'd9;
        repeat (3) @(negedge clk);
        start_i = 1'b0;
        wait_done();
        // Back-to-back: accepted in the IDLE cycle right after done.
        run_op(3'd1, 8'd64);

        // Start raised only in the DONE cycle must be dropped.
        start_op(3'd0, 8'd16);
        wait_done();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("done_cycle_start_busy", int'(busy_o), 0);

        // Reset mid-search aborts with no done pulse.
        start_op(3'd1, 8'd255);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle_zero("abort");
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        run_op(3'd1, 8'd255);

        for (int i = 0; i < 10; i++) begin
            run_op(3'($urandom_range(0, 4)), 8'($urandom_range(0, 255)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
